// File: rtl/wb_xbar_rr_if.sv
// Wishbone classic shared-bus crossbar signal bundle.
// The "slave" modport is the crossbar view; "master" is the surrounding system.
interface wb_xbar_rr_if #(
   parameter int unsigned N_MST  = 2,
   parameter int unsigned N_SLV  = 8,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned SEL_W = DATA_W / 8;

   logic [N_MST*ADDR_W-1:0] m_adr_i;
   logic [N_MST*DATA_W-1:0] m_dat_i;
   logic [N_MST*SEL_W-1:0]  m_sel_i;
   logic [N_MST-1:0]        m_we_i;
   logic [N_MST-1:0]        m_cyc_i;
   logic [N_MST-1:0]        m_stb_i;
   logic [DATA_W-1:0]       m_dat_o;
   logic [N_MST-1:0]        m_ack_o;
   logic [N_MST-1:0]        m_err_o;

   logic [ADDR_W-1:0]       s_adr_o;
   logic [DATA_W-1:0]       s_dat_o;
   logic [SEL_W-1:0]        s_sel_o;
   logic                    s_we_o;
   logic [N_SLV-1:0]        s_cyc_o;
   logic [N_SLV-1:0]        s_stb_o;
   logic [N_SLV*DATA_W-1:0] s_dat_i;
   logic [N_SLV-1:0]        s_ack_i;

   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
      input  s_dat_i, s_ack_i
   );

   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
      output s_dat_i, s_ack_i
   );
endinterface

// File: rtl/wb_xbar_rr.sv
// Round-robin shared-bus Wishbone interconnect: N masters, M slaves,
// prefix decode, error on unmapped access, ack watchdog.
module wb_xbar_rr #(
   parameter int unsigned N_MST  = 2,
   parameter int unsigned N_SLV  = 8,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PFX_W  = 4,
   parameter logic [N_SLV*PFX_W-1:0] SLV_PFX = '0,
   parameter logic [N_SLV-1:0]       SLV_EN  = '1,
   parameter int unsigned TIMEOUT = 255
) (
   input logic         clk,
   input logic         rst_n,
   wb_xbar_rr_if.slave bus
);
   localparam int unsigned SEL_W = DATA_W / 8;
   localparam int unsigned GW = (N_MST > 1) ? $clog2(N_MST) : 1;
   localparam int unsigned SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e           state_q, state_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [GW-1:0]    last_q, last_d;
   logic [WW-1:0]    wdog_q, wdog_d;
   logic [N_MST-1:0] err_q, err_d;
   logic             kill_q, kill_d;

   logic [ADDR_W-1:0] adr_g;
   logic [DATA_W-1:0] dat_g;
   logic [SEL_W-1:0]  sel_g;
   logic              we_g, cyc_g, stb_g;

   logic [N_SLV-1:0] hit;
   logic [SW-1:0]    hit_idx;
   logic             any_hit;
   logic             ack_s;
   logic             busy, act;
   logic [GW-1:0]    pick;
   logic             found;

   logic [N_SLV-1:0]  s_cyc, s_stb;
   logic [N_MST-1:0]  m_ack;
   logic [DATA_W-1:0] m_dat;

   always_comb begin
      adr_g = bus.m_adr_i[int'(grant_q)*ADDR_W +: ADDR_W];
      dat_g = bus.m_dat_i[int'(grant_q)*DATA_W +: DATA_W];
      sel_g = bus.m_sel_i[int'(grant_q)*SEL_W +: SEL_W];
      we_g  = bus.m_we_i[grant_q];
      cyc_g = bus.m_cyc_i[grant_q];
      stb_g = bus.m_stb_i[grant_q];
   end

   // Scan downwards so the lowest matching slave index wins.
   always_comb begin
      hit     = '0;
      hit_idx = '0;
      any_hit = 1'b0;
      for (int k = N_SLV - 1; k >= 0; k--) begin
         if (SLV_EN[k] &&
             adr_g[ADDR_W-1 -: PFX_W] == SLV_PFX[k*PFX_W +: PFX_W]) begin
            hit_idx = SW'(k);
            any_hit = 1'b1;
         end
      end
      if (any_hit) hit[hit_idx] = 1'b1;
   end

   always_comb begin
      pick  = last_q;
      found = 1'b0;
      for (int i = 1; i <= N_MST; i++) begin
         if (!found && bus.m_cyc_i[(int'(last_q) + i) % N_MST]) begin
            pick  = GW'((int'(last_q) + i) % N_MST);
            found = 1'b1;
         end
      end
   end

   assign busy  = (state_q == BUSY);
   assign act   = busy & cyc_g & ~kill_q;
   assign ack_s = any_hit & bus.s_ack_i[hit_idx];

   always_comb begin
      s_cyc = act ? hit : '0;
      s_stb = (act & stb_g) ? hit : '0;
      m_ack = '0;
      if (act & stb_g & ack_s) m_ack[grant_q] = 1'b1;
      m_dat = '0;
      if (busy & any_hit) m_dat = bus.s_dat_i[int'(hit_idx)*DATA_W +: DATA_W];
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wdog_d  = wdog_q;
      err_d   = '0;
      kill_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (found) begin
               state_d = BUSY;
               grant_d = pick;
            end
         end
         BUSY: begin
            if (!cyc_g) begin
               state_d = IDLE;
               last_d  = grant_q;
               wdog_d  = '0;
            end else if (!stb_g) begin
               wdog_d = '0;
            end else if (!any_hit) begin
               // Held strobe to nowhere: err every second cycle.
               err_d[grant_q] = ~err_q[grant_q];
               wdog_d = '0;
            end else if (kill_q || ack_s) begin
               wdog_d = '0;
            end else if (TIMEOUT != 0 && wdog_q == WD_MAX) begin
               err_d[grant_q] = 1'b1;
               kill_d = 1'b1;
               wdog_d = '0;
            end else begin
               wdog_d = wdog_q + WW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= GW'(N_MST - 1);
         wdog_q  <= '0;
         err_q   <= '0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
         err_q   <= err_d;
         kill_q  <= kill_d;
      end
   end

   assign bus.s_adr_o = adr_g;
   assign bus.s_dat_o = dat_g;
   assign bus.s_sel_o = sel_g;
   assign bus.s_we_o  = we_g;
   assign bus.s_cyc_o = s_cyc;
   assign bus.s_stb_o = s_stb;
   assign bus.m_ack_o = m_ack;
   assign bus.m_err_o = err_q;
   assign bus.m_dat_o = m_dat;
endmodule
